mult_share_arbiter: RTL and testbench

- Shares one signed Booth multiplier (start/ready/product interface, operands word1/word2) among N_REQ independent requesters.
- Round-robin arbitration; latches the winner's operands and drives a one-cycle start pulse.
- Waits for the multiplier to return to ready, then returns the product to the winner with a one-cycle response pulse.
- Includes a watchdog so a hung multiplier cannot lock out the requesters.

---
 rtl/mult_share_arbiter_pkg.sv | 34 +++
 rtl/mult_share_arbiter_rr_pick.sv | 30 +++
 rtl/mult_share_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// rtl/mult_share_arbiter_pkg.sv - shared state encoding and width helpers for the multiplier arbiter
package mult_share_arbiter_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_ISSUE  = S_ISSUE,
    ST_SETTLE = S_SETTLE,
    ST_WAIT   = S_WAIT,
    ST_RESP   = S_RESP
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // An index needs at least one bit even for a degenerate single-entry vector.
  function automatic int idx_width(input int n_req);
    return (clog2(n_req) < 1) ? 1 : clog2(n_req);
  endfunction

  function automatic int prod_width(input int l_word);
    return 2 * l_word;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rtl/mult_share_arbiter_rr_pick.sv - combinational round-robin picker, search starts just after rr_ptr
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int               j;
  logic [IDX_W-1:0] j_idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    j_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j     = (int'(rr_ptr) + k) % N_REQ;
      j_idx = IDX_W'(j);
      if (!found && req[j_idx]) begin
        found = 1'b1;
        idx   = j_idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one start/ready multiplier among N_REQ requesters
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int l_word  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*l_word-1:0]   req_word1,
  input  logic [N_REQ*l_word-1:0]   req_word2,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [2*l_word-1:0]       rsp_product,
  output logic                      busy,
  output logic                      err,
  output logic                      m_start,
  output logic [l_word-1:0]         m_word1,
  output logic [l_word-1:0]         m_word2,
  input  logic                      m_ready,
  input  logic [2*l_word-1:0]       m_product
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int P_W   = prod_width(l_word);
  localparam int WD_W  = clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, rr_ptr_q, pick_idx;
  logic              pick_found;
  logic [WD_W-1:0]   wd_q;
  logic              wd_last;
  logic              grant_now;
  logic [N_REQ-1:0]  eff_req;
  logic [N_REQ-1:0]  one_lsb;

  // The requester just answered may still hold req during its rsp_valid cycle.
  assign eff_req   = req & ~rsp_valid;
  assign grant_now = (state_q == ST_IDLE) && m_ready && pick_found;
  assign wd_last   = (wd_q == WD_W'(TIMEOUT - 1));
  assign one_lsb   = {{(N_REQ-1){1'b0}}, 1'b1};

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (eff_req),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_now) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT:   if (m_ready || wd_last) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
      err         <= 1'b0;
      m_start     <= 1'b0;
      m_word1     <= '0;
      m_word2     <= '0;
      idx_q       <= '0;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      wd_q        <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      m_start   <= 1'b0;
      busy      <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (grant_now) begin
            idx_q   <= pick_idx;
            gnt     <= one_lsb << pick_idx;
            m_word1 <= req_word1[int'(pick_idx)*l_word +: l_word];
            m_word2 <= req_word2[int'(pick_idx)*l_word +: l_word];
          end
        end
        ST_ISSUE:  m_start <= 1'b1;
        ST_SETTLE: wd_q <= '0;
        ST_WAIT: begin
          // A late ready on the expiring cycle still wins over the abort.
          if (m_ready) begin
            rsp_product <= m_product;
          end else if (wd_last) begin
            err         <= 1'b1;
            rsp_product <= {P_W{1'b0}};
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_valid <= one_lsb << idx_q;
          rr_ptr_q  <= idx_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for the multiplier-sharing arbiter
module tb_mult_share_arbiter;

  localparam int N_REQ   = 4;
  localparam int LW      = 4;
  localparam int PW      = 8;
  localparam int TIMEOUT = 64;

  typedef struct {
    int         idx;
    logic [7:0] prod;
    int         lat;
  } rsp_t;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*LW-1:0]    req_word1 = '0;
  logic [N_REQ*LW-1:0]    req_word2 = '0;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [PW-1:0]          rsp_product;
  logic                   busy;
  logic                   err;
  logic                   m_start;
  logic [LW-1:0]          m_word1;
  logic [LW-1:0]          m_word2;
  logic                   m_ready;
  logic [PW-1:0]          m_product;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  logic hang = 1'b0;
  int   stub_cnt;
  logic [PW-1:0] stub_res;
  logic [N_REQ-1:0] gnt_prev = '0;

  int   gnt_q[$];
  rsp_t rsp_q[$];

  always #5 clock = ~clock;

  mult_share_arbiter #(
    .N_REQ   (N_REQ),
    .l_word  (LW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_word1   (req_word1),
    .req_word2   (req_word2),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy),
    .err         (err),
    .m_start     (m_start),
    .m_word1     (m_word1),
    .m_word2     (m_word2),
    .m_ready     (m_ready),
    .m_product   (m_product)
  );

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [3:0] sa, sb;
    logic signed [7:0] r;
    sa = a;
    sb = b;
    r  = sa * sb;
    return r;
  endfunction

  // Multiplier stub: 3-cycle latency, zero operands keep it ready with product 0, hang freezes it.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ready   <= 1'b1;
      m_product <= '0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else if (m_start && m_ready) begin
      if (m_word1 == '0 || m_word2 == '0) begin
        m_product <= '0;
      end else begin
        m_ready  <= 1'b0;
        stub_cnt <= 3;
        stub_res <= smul(m_word1, m_word2);
      end
    end else if (!m_ready && !hang) begin
      if (stub_cnt <= 1) begin
        m_ready   <= 1'b1;
        m_product <= stub_res;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_rsp(input int idx, input logic [7:0] prod, input int lat);
    rsp_t e;
    e.idx  = idx;
    e.prod = prod;
    e.lat  = lat;
    rsp_q.push_back(e);
    gnt_q.push_back(idx);
  endtask

  task automatic do_req(input int i, input logic [3:0] w1, input logic [3:0] w2);
    bit got;
    got = 1'b0;
    @(negedge clock);
    req[i] = 1'b1;
    req_word1[i*LW +: LW] = w1;
    req_word2[i*LW +: LW] = w2;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clock);
      if (gnt[i]) begin
        chk("busy_at_gnt", {31'd0, busy}, 32'd1);
        req_word1[i*LW +: LW] = ~w1;
        req_word2[i*LW +: LW] = ~w2;
      end
      if (rsp_valid[i]) got = 1'b1;
    end
    req[i] = 1'b0;
    chk("rsp_arrived", {31'd0, got}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       {28'd0, gnt}, 32'd0);
    chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_prod"},  {24'd0, rsp_product}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
    chk({tag, "_err"},       {31'd0, err}, 32'd0);
    chk({tag, "_m_start"},   {31'd0, m_start}, 32'd0);
    chk({tag, "_m_word1"},   {28'd0, m_word1}, 32'd0);
    chk({tag, "_m_word2"},   {28'd0, m_word2}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response.
  initial begin
    int   e;
    rsp_t r;
    logic [N_REQ-1:0] oh;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        if (gnt != '0) begin
          gnt_cyc = cyc;
          if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", {28'd0, gnt}, 32'd0);
          end else begin
            e = gnt_q.pop_front();
            oh = '0;
            oh[e] = 1'b1;
            chk("gnt_order", {28'd0, gnt}, {28'd0, oh});
          end
        end
        if (gnt_prev != '0 || m_start)
          chk("start_after_gnt", {31'd0, m_start}, {31'd0, (gnt_prev != '0)});
        if (m_start)
          chk("start_mult_ready", {31'd0, m_ready}, 32'd1);
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
          end else begin
            r = rsp_q.pop_front();
            oh = '0;
            oh[r.idx] = 1'b1;
            chk("rsp_valid_onehot", {28'd0, rsp_valid}, {28'd0, oh});
            chk("rsp_product", {24'd0, rsp_product}, {24'd0, r.prod});
            if (r.lat > 0) chk("rsp_latency", cyc - gnt_cyc, r.lat);
            else           chk("rsp_latency_min", {31'd0, (cyc - gnt_cyc) >= 4}, 32'd1);
          end
        end
        gnt_prev = gnt;
      end else begin
        gnt_prev = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit got;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    push_rsp(0, 8'h0F, 0);
    do_req(0, 4'd3, 4'd5);
    chk("busy_after_resp", {31'd0, busy}, 32'd0);

    push_rsp(2, 8'hF1, 0);
    do_req(2, 4'hD, 4'h5);

    push_rsp(3, 8'h31, 0);
    do_req(3, 4'h7, 4'h7);

    push_rsp(0, 8'h06, 0);
    push_rsp(1, 8'hC8, 0);
    push_rsp(2, 8'h01, 0);
    push_rsp(3, 8'hF4, 0);
    fork
      do_req(0, 4'h2, 4'h3);
      do_req(1, 4'h8, 4'h7);
      do_req(2, 4'hF, 4'hF);
      do_req(3, 4'h6, 4'hE);
    join

    push_rsp(1, 8'h00, 4);
    do_req(1, 4'h0, 4'h7);

    hang = 1'b1;
    push_rsp(3, 8'h00, 0);
    do_req(3, 4'h2, 4'h2);
    chk("err_after_timeout", {31'd0, err}, 32'd1);
    hang = 1'b0;
    push_rsp(1, 8'hFB, 0);
    do_req(1, 4'h5, 4'hF);
    chk("err_sticky", {31'd0, err}, 32'd1);

    hang = 1'b1;
    gnt_q.push_back(0);
    @(negedge clock);
    req[0] = 1'b1;
    req_word1[3:0] = 4'h3;
    req_word2[3:0] = 4'h3;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clock);
      if (gnt[0]) got = 1'b1;
    end
    req[0] = 1'b0;
    chk("reset_job_gnt", {31'd0, got}, 32'd1);
    repeat (5) @(posedge clock);
    chk("busy_mid_wait", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    hang = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("no_rsp_after_reset", {28'd0, rsp_valid}, 32'd0);

    push_rsp(0, 8'h40, 0);
    do_req(0, 4'h8, 4'h8);

    repeat (20) @(negedge clock);
    chk("rsp_queue_drained", rsp_q.size(), 32'd0);
    chk("gnt_queue_drained", gnt_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
